fifo_drain_packer: RTL

FIFO_DRAIN_PACKER -- requirements
Module: fifo_drain_packer

---
 rtl/fifo_drain_packer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fifo_drain_packer.sv
// rtl/fifo_drain_packer.sv - drains a synchronous FIFO and packs word pairs into double-width output words
// Optional partial flush of a stranded low half is enabled by defining PACKER_FLUSH_EN.
module fifo_drain_packer #(
  parameter int FIFO_WIDTH   = 16,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [FIFO_WIDTH-1:0]   fifo_data_out,
  output logic                    fifo_rd_en,
  output logic [2*FIFO_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_partial,
  output logic [15:0]             word_cnt
);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be at least 1");
  end

  logic [FIFO_WIDTH-1:0]   lo_q;
  logic                    have_lo_q;
  logic                    inflight_q;
  logic [2*FIFO_WIDTH-1:0] data_q;
  logic                    valid_q;
  logic [15:0]             word_cnt_q;

  logic capture_lo;
  logic complete;
  logic accept;
  logic out_free;
  logic lo_survives;
  logic flush;

  always_comb begin
    capture_lo  = inflight_q && !have_lo_q;
    complete    = inflight_q && have_lo_q;
    accept      = valid_q && m_ready;
    out_free    = !valid_q || m_ready;
    // Occupancy is judged after this cycle's capture/pairing, so a pair completing
    // now frees both slots and back-to-back reads continue at full rate.
    lo_survives = inflight_q ^ have_lo_q;
    fifo_rd_en  = !rst && !fifo_empty && (!lo_survives || out_free);
  end

`ifdef PACKER_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);

  logic [IDLE_W-1:0] idle_q;
  logic              idle_cond;
  logic              partial_q;

  always_comb begin
    idle_cond = have_lo_q && !inflight_q && fifo_empty;
    flush     = idle_cond && (idle_q >= IDLE_W'(FLUSH_CYCLES)) && out_free;
  end

  // Saturates at FLUSH_CYCLES while the output is still busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (flush || !idle_cond) begin
      idle_q <= '0;
    end else if (idle_q < IDLE_W'(FLUSH_CYCLES)) begin
      idle_q <= idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      partial_q <= 1'b0;
    end else if (flush) begin
      partial_q <= 1'b1;
    end else if (complete) begin
      partial_q <= 1'b0;
    end
  end

  assign m_partial = partial_q;
`else
  assign flush     = 1'b0;
  assign m_partial = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q       <= '0;
      have_lo_q  <= 1'b0;
      inflight_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= fifo_rd_en;

      if (capture_lo) begin
        lo_q      <= fifo_data_out;
        have_lo_q <= 1'b1;
      end else if (complete || flush) begin
        have_lo_q <= 1'b0;
      end

      if (complete) begin
        data_q  <= {fifo_data_out, lo_q};
        valid_q <= 1'b1;
      end else if (flush) begin
        data_q  <= {{FIFO_WIDTH{1'b0}}, lo_q};
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (accept) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
    end
  end

  assign m_data   = data_q;
  assign m_valid  = valid_q;
  assign word_cnt = word_cnt_q;

endmodule
